// File: rtl/logic_op_scheduler_if.sv
// Request/response bundle for logic_op_scheduler; master = requesters + consumer, slave = scheduler.
interface logic_op_scheduler_if #(
  parameter int WIDTH   = 2,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/logic_op_scheduler.sv
// Round-robin share of one AND/OR/XOR/XNOR unit; accept->rsp_valid 2 edges, result held until rsp_ready.
// No new request is accepted until the response handshakes; LOGIC_SCHED_STATS_EN adds stat_done/stat_stall.
module logic_op_scheduler #(
  parameter int WIDTH   = 2,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_op_scheduler_if.slave  bus
`ifdef LOGIC_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_done,
  output logic [15:0]          stat_stall
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [NUM_REQ-1:0] REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_grant;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;

  logic             w_found;
  logic [ID_W-1:0]  w_grant;
  int               w_idx;
  logic             w_accept;
  logic             w_rsp_hs;
  logic [WIDTH-1:0] w_result;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = ID_W'(w_idx);
      end
    end
  end

  assign w_accept      = (r_state == S_IDLE) && w_found;
  assign w_rsp_hs      = (r_state == S_RESP) && bus.rsp_ready;
  assign bus.req_ready = w_accept ? (REQ_ONE << w_grant) : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = (r_state != S_IDLE);

  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = r_a & r_b;
      2'b01:   w_result = r_a | r_b;
      2'b10:   w_result = r_a ^ r_b;
      default: w_result = ~(r_a ^ r_b);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.req_op[2*int'(w_grant) +: 2];
            r_a     <= bus.req_a[WIDTH*int'(w_grant) +: WIDTH];
            r_b     <= bus.req_b[WIDTH*int'(w_grant) +: WIDTH];
            r_grant <= w_grant;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_id    <= r_grant;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LOGIC_SCHED_STATS_EN
  logic [15:0] r_stat_done;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_done  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_rsp_hs && (r_stat_done != 16'hFFFF))
        r_stat_done <= r_stat_done + 16'd1;
      if ((r_state == S_RESP) && !bus.rsp_ready && (r_stat_stall != 16'hFFFF))
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_done  = r_stat_done;
  assign stat_stall = r_stat_stall;
`else
  logic w_unused;
  assign w_unused = w_rsp_hs;
`endif

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Self-checking bench for logic_op_scheduler against a transaction-level round-robin model.
module tb_logic_op_scheduler;
  localparam int WIDTH   = 2;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;

  always #5 clk = ~clk;

  logic_op_scheduler_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef LOGIC_SCHED_STATS_EN
  logic [15:0] stat_done;
  logic [15:0] stat_stall;
`endif

  logic_op_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef LOGIC_SCHED_STATS_EN
    ,
    .stat_done  (stat_done),
    .stat_stall (stat_stall)
`endif
  );

  function automatic logic [1:0] model_op(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic int model_grant(input logic [1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [1:0] exp_rdy(input int g);
    return (g < 0) ? 2'b00 : (2'b01 << g);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Drives one request set at a negedge with rsp_ready=1; returns what it observed.
  task automatic run_op(input logic [1:0] v, input logic [3:0] ops, input logic [3:0] as,
                        input logic [3:0] bs, output logic [1:0] rdy, output int lat,
                        output logic [1:0] data, output logic id);
    bus.req_valid = v;
    bus.req_op    = ops;
    bus.req_a     = as;
    bus.req_b     = bs;
    bus.rsp_ready = 1'b1;
    #1;
    rdy  = bus.req_ready;
    lat  = 99;
    data = '0;
    id   = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.req_valid = '0;
      if (bus.rsp_valid) begin
        lat  = c;
        data = bus.rsp_data;
        id   = bus.rsp_id;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++;
    if (bus.rsp_data !== 2'b00) begin errors++; $display("FAIL reset_rsp_data got=%b exp=00", bus.rsp_data); end
    checks++;
    if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%b exp=0", bus.rsp_id); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
  endtask

  task automatic test_single_op();
    logic [1:0] rdy, data;
    logic       id;
    int         lat;
    run_op(2'b01, 4'b0000, 4'b0011, 4'b0010, rdy, lat, data, id);
    checks++;
    if (rdy !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", rdy); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", lat); end
    checks++;
    if (data !== 2'b10) begin errors++; $display("FAIL single_data got=%b exp=10", data); end
    checks++;
    if (id !== 1'b0) begin errors++; $display("FAIL single_id got=%b exp=0", id); end
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle_after busy=%b rsp_valid=%b exp=0,0", bus.busy, bus.rsp_valid);
    end
    m_ptr = 1;
  endtask

  task automatic test_opcodes();
    logic [1:0] rdy, data;
    logic [1:0] exp_tab [3];
    logic       id;
    int         lat;
    exp_tab[0] = 2'b11;
    exp_tab[1] = 2'b10;
    exp_tab[2] = 2'b01;
    for (int op = 1; op <= 3; op++) begin
      run_op(2'b10, {2'(op), 2'b00}, 4'b0100, 4'b1100, rdy, lat, data, id);
      checks++;
      if (rdy !== 2'b10 || lat !== 2 || id !== 1'b1 || data !== exp_tab[op-1]) begin
        errors++;
        $display("FAIL opcode_%0d got rdy=%b lat=%0d id=%b data=%b exp rdy=10 lat=2 id=1 data=%b",
                 op, rdy, lat, id, data, exp_tab[op-1]);
      end
      m_ptr = 0;
    end
  endtask

  task automatic test_idle();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({bus.req_ready, bus.busy, bus.rsp_valid} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_quiet got ready=%b busy=%b rsp_valid=%b exp 00,0,0", bus.req_ready, bus.busy, bus.rsp_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [1:0] rdy, data, v, ed;
    logic [3:0] ops, as, bs;
    logic       id;
    int         lat, g;
    for (int it = 0; it < 24; it++) begin
      v   = 2'($urandom_range(1, 3));
      ops = 4'($urandom);
      as  = 4'($urandom);
      bs  = 4'($urandom);
      g   = model_grant(v);
      ed  = model_op(ops[2*g +: 2], as[2*g +: 2], bs[2*g +: 2]);
      run_op(v, ops, as, bs, rdy, lat, data, id);
      checks++;
      if (rdy !== exp_rdy(g) || lat !== 2 || id !== 1'(g) || data !== ed) begin
        errors++;
        $display("FAIL random_%0d v=%b got rdy=%b lat=%0d id=%b data=%b exp rdy=%b lat=2 id=%0d data=%b",
                 it, v, rdy, lat, id, data, exp_rdy(g), g, ed);
      end
      m_ptr = (g + 1) % NUM_REQ;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] grants [$];
    logic       ids [$];
    int         m0;
    m0 = m_ptr;
    bus.req_valid = 2'b11;
    bus.req_op    = 4'b0110;
    bus.req_a     = 4'($urandom);
    bus.req_b     = 4'($urandom);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.req_ready !== 2'b00) grants.push_back(bus.req_ready);
      else if (grants.size() >= 4) bus.req_valid = 2'b00;
      if (bus.rsp_valid === 1'b1) ids.push_back(bus.rsp_id);
      if (ids.size() == 4) break;
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (grants.size() < 4 || ids.size() < 4) begin
      errors++; $display("FAIL rr_count grants=%0d rsps=%0d exp 4,4", grants.size(), ids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] !== exp_rdy((m0 + i) % NUM_REQ) || ids[i] !== 1'((m0 + i) % NUM_REQ)) begin
          errors++;
          $display("FAIL rr_order_%0d got ready=%b id=%b exp ready=%b id=%0d",
                   i, grants[i], ids[i], exp_rdy((m0 + i) % NUM_REQ), (m0 + i) % NUM_REQ);
        end
      end
    end
    m_ptr = (m0 + 4) % NUM_REQ;
  endtask

  task automatic test_backpressure();
    logic [1:0] a0, b0, ed;
    do_reset();
    a0 = 2'($urandom);
    b0 = 2'($urandom);
    ed = model_op(2'b10, a0, b0);
    bus.req_valid = 2'b01;
    bus.req_op    = 4'b0010;
    bus.req_a     = {2'b00, a0};
    bus.req_b     = {2'b00, b0};
    bus.rsp_ready = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_ready got=%b exp=01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b11;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ed || bus.rsp_id !== 1'b0 ||
          bus.req_ready !== 2'b00 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d got valid=%b data=%b id=%b ready=%b busy=%b exp 1,%b,0,00,1",
                 k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready, bus.busy, ed);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got valid=%b busy=%b exp 0,0", bus.rsp_valid, bus.busy);
    end
`ifdef LOGIC_SCHED_STATS_EN
    checks++;
    if (stat_stall !== 16'd5) begin errors++; $display("FAIL bp_stat_stall got=%0d exp=5", stat_stall); end
    checks++;
    if (stat_done !== 16'd1) begin errors++; $display("FAIL bp_stat_done got=%0d exp=1", stat_done); end
`endif
    m_ptr = 1;
  endtask

  task automatic test_reset_mid_op();
    logic [1:0] rdy, data;
    logic       id;
    int         lat;
    bus.req_valid = 2'b01;
    bus.req_op    = 4'b0000;
    bus.req_a     = 4'b1111;
    bus.req_b     = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== exp_rdy(model_grant(2'b01))) begin
      errors++; $display("FAIL midrst_ready got=%b exp=01", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_abort got valid=%b busy=%b exp 0,0", bus.rsp_valid, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_replay got valid=%b exp=0", bus.rsp_valid); end
    run_op(2'b11, 4'b0101, 4'b1001, 4'b0011, rdy, lat, data, id);
    checks++;
    if (rdy !== 2'b01 || id !== 1'b0 || lat !== 2 || data !== 2'b11) begin
      errors++; $display("FAIL midrst_ptr got rdy=%b id=%b lat=%0d data=%b exp 01,0,2,11", rdy, id, lat, data);
    end
    m_ptr = 1;
    run_op(2'b10, 4'b1000, 4'b1100, 4'b0100, rdy, lat, data, id);
    checks++;
    if (rdy !== 2'b10 || id !== 1'b1 || lat !== 2 || data !== 2'b10) begin
      errors++; $display("FAIL midrst_req1 got rdy=%b id=%b lat=%0d data=%b exp 10,1,2,10", rdy, id, lat, data);
    end
    m_ptr = 0;
  endtask

`ifdef LOGIC_SCHED_STATS_EN
  task automatic test_saturation();
    logic [1:0] rdy, data;
    logic       id;
    int         lat;
    do_reset();
    dut.r_stat_done = 16'hFFFD;
    for (int i = 0; i < 4; i++) run_op(2'b01, 4'b0001, 4'b0011, 4'b0001, rdy, lat, data, id);
    checks++;
    if (stat_done !== 16'hFFFF) begin errors++; $display("FAIL sat_stat_done got=%h exp=ffff", stat_done); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_op();
    test_opcodes();
    test_idle();
    test_random();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
`ifdef LOGIC_SCHED_STATS_EN
    test_saturation();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
